// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between two requesters.
//   Port 0 is the CPU load/store path. Port 1 is the program/data loader.
//   One request is accepted per cycle. The winner drives the memory for one ACCESS cycle, and
//   its read data comes back one cycle after that. The CPU has priority, but a starvation
//   counter forces a grant to port 1 once it has been denied STARVE_LIMIT cycles in a row.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*/funct3_* request valid and payload per port
//   gnt0/gnt1                     combinational grant, the request is taken at this edge
//   rvalid0/rvalid1, rdata        one-cycle read response pulse per owner, shared data
//   cpu_stall                     port 0 is requesting but was not granted
//   mem_addr/mem_wdata/mem_we/mem_funct3/mem_rdata  DataMemory side
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [2:0]            funct3_0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [2:0]            funct3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  cpu_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Arbitration and starvation counter.
  always_comb begin
    gnt1      = req1 & (~req0 | (starve_cnt_q == CntMax));
    gnt0      = req0 & ~gnt1;
    cpu_stall = req0 & ~gnt0;

    starve_cnt_d = starve_cnt_q;
    if (!req1 || gnt1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CntMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Next state, request latch and response.
  always_comb begin
    state_d  = StIdle;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;

    if (gnt1) begin
      state_d  = StAccess;
      owner_d  = 1'b1;
      we_d     = we1;
      addr_d   = addr1;
      wdata_d  = wdata1;
      funct3_d = funct3_1;
    end else if (gnt0) begin
      state_d  = StAccess;
      owner_d  = 1'b0;
      we_d     = we0;
      addr_d   = addr0;
      wdata_d  = wdata0;
      funct3_d = funct3_0;
    end

    // The response closes out whichever access is running, stores included.
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata_d   = rdata_q;
    if (state_q == StAccess) begin
      rvalid0_d = ~owner_q;
      rvalid1_d = owner_q;
      rdata_d   = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata_q      <= rdata_d;
    end
  end

  // The latch is only loaded on a grant, so in IDLE the address, data and width hold their
  // last values and only the write enable has to be gated.
  always_comb begin
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    mem_funct3 = funct3_q;
    mem_we     = (state_q == StAccess) & we_q;
    rvalid0    = rvalid0_q;
    rvalid1    = rvalid1_q;
    rdata      = rdata_q;
  end

endmodule
